// File: rtl/pwm_generator.sv
// PWM generator with prescaled tick, phase counter and a shadow duty register
// that only reloads at period boundaries, so pulses are never cut or stretched.
module pwm_generator #(
   parameter int N     = 3,
   parameter int PSC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     level,
   input  logic [N-1:0]     top,
   input  logic [PSC_W-1:0] prescale,
   output logic             pwm_out,
   output logic             period_start,
   output logic [N-1:0]     duty_q
);

   // state   | meaning
   // ST_IDLE | disabled, counters and output held at 0, duty_q retained
   // ST_RUN  | generating periods of (prescale+1)*(top+1) clk cycles
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [PSC_W-1:0] psc_cnt, psc_nxt;
   logic [N-1:0]     phase, phase_nxt;
   logic [N-1:0]     duty_nxt;
   logic [N-1:0]     level_clamped;
   logic             tick;
   logic             ps_nxt;
   logic             pwm_nxt;

   assign level_clamped = (level > top) ? top : level;
   assign tick          = (psc_cnt == prescale);

   always_comb begin
      state_nxt = state;
      psc_nxt   = '0;
      phase_nxt = '0;
      duty_nxt  = duty_q;
      ps_nxt    = 1'b0;
      pwm_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               state_nxt = ST_RUN;
               duty_nxt  = level_clamped;
               ps_nxt    = 1'b1;
               pwm_nxt   = (level_clamped != '0);
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_nxt = ST_IDLE;
            end else begin
               if (tick) begin
                  if (phase == top) begin
                     duty_nxt = level_clamped;
                     ps_nxt   = 1'b1;
                  end else begin
                     phase_nxt = phase + 1'b1;
                  end
               end else begin
                  psc_nxt   = psc_cnt + 1'b1;
                  phase_nxt = phase;
               end
               // Compare against the values being registered so pwm_out
               // always agrees with phase/duty_q in the same cycle.
               pwm_nxt = (phase_nxt < duty_nxt);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         psc_cnt      <= '0;
         phase        <= '0;
         duty_q       <= '0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state        <= state_nxt;
         psc_cnt      <= psc_nxt;
         phase        <= phase_nxt;
         duty_q       <= duty_nxt;
         pwm_out      <= pwm_nxt;
         period_start <= ps_nxt;
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed scenarios plus randomized segments,
// compared every cycle against a period-arithmetic reference model.
module tb_pwm_generator;

   localparam int N     = 3;
   localparam int PSC_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [N-1:0]     level = '0;
   logic [N-1:0]     top = '0;
   logic [PSC_W-1:0] prescale = '0;
   logic             pwm_out;
   logic             period_start;
   logic [N-1:0]     duty_q;

   int n_vec = 0;
   int n_err = 0;

   pwm_generator #(.N(N), .PSC_W(PSC_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .level        (level),
      .top          (top),
      .prescale     (prescale),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty_q       (duty_q)
   );

   always #5 clk = ~clk;

   // Reference: cycles elapsed since the enabling edge, folded into the period.
   bit m_run = 1'b0;
   int m_t = 0;
   int m_duty = 0;
   bit m_pwm = 1'b0;
   bit m_ps = 1'b0;
   int m_tick_len;
   int m_per;
   int m_k;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run  = 1'b0;
         m_t    = 0;
         m_duty = 0;
         m_pwm  = 1'b0;
         m_ps   = 1'b0;
      end else if (!en) begin
         m_run = 1'b0;
         m_pwm = 1'b0;
         m_ps  = 1'b0;
      end else begin
         if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
         end else begin
            m_t = m_t + 1;
         end
         m_tick_len = int'(prescale) + 1;
         m_per      = m_tick_len * (int'(top) + 1);
         m_k        = m_t % m_per;
         if (m_k == 0)
            m_duty = (level > top) ? int'(top) : int'(level);
         m_ps  = (m_k == 0);
         m_pwm = ((m_k / m_tick_len) < m_duty);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check_val("period_start", 32'(period_start), 32'(m_ps));
      check_val("duty_q", 32'(duty_q), 32'(m_duty));
   endtask

   task automatic cycles(input int n, input int chg_pct);
      repeat (n) begin
         @(negedge clk);
         check_outputs();
         if (int'($urandom_range(99)) < chg_pct)
            level = N'($urandom_range(0, (1 << N) - 1));
      end
   endtask

   task automatic configure(input int t, input int p, input int l);
      en = 1'b0;
      cycles(2, 0);
      top      = N'(t);
      prescale = PSC_W'(p);
      level    = N'(l);
      en       = 1'b1;
   endtask

   initial begin
      #1 rst = 1'b0;
      #2 check_outputs();
      @(negedge clk);
      check_outputs();
      rst = 1'b1;

      // basic duty 2/5
      configure(4, 0, 2);
      cycles(16, 0);

      // prescaled 3/5 with 4 clk per tick
      configure(4, 3, 3);
      cycles(42, 0);

      // level change two cycles into a period
      configure(4, 0, 1);
      cycles(3, 0);
      level = 3'd4;
      cycles(12, 0);

      // clamp, zero duty, and top=0
      configure(4, 0, 7);
      cycles(12, 0);
      configure(4, 0, 0);
      cycles(12, 0);
      configure(0, 2, 5);
      cycles(10, 0);

      // disable during the high pulse, then re-enable with a new level
      configure(4, 0, 3);
      cycles(2, 0);
      en = 1'b0;
      cycles(1, 0);
      level = 3'd1;
      en    = 1'b1;
      cycles(8, 0);

      // asynchronous reset in the middle of a period
      configure(4, 1, 2);
      cycles(7, 0);
      #2 rst = 1'b0;
      #1 check_outputs();
      @(negedge clk);
      check_outputs();
      rst = 1'b1;
      cycles(14, 0);

      for (int seg = 0; seg < 25; seg++) begin
         configure(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)));
         cycles(int'($urandom_range(10, 40)), 15);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
